// File: rtl/instr_encoder.sv
// Field-level instruction encoder + program loader; optional macro ENC_ADDR_WRAP_EN (pointer wrap instead of halt).
// Latency: request accepted at edge N drives mem_we/mem_wdata in the following cycle (empty FIFO).
// Backpressure: in_ready drops when the FIFO is full, the address space is exhausted, or start is high.

module enc_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic [W-1:0]               head_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

    assign cnt      = wr_q - rd_q;
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign empty    = (cnt == '0);
    assign head_dat = mem_q[rd_q[AW-1:0]];
endmodule

module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [5:0]        in_imm,
    input  logic [7:0]        in_jaddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err_illegal,
    output logic              addr_full
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
`ifdef ENC_ADDR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic              err_q;
    logic [15:0]       enc_word;
    logic              legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic [15:0]       fifo_head;

    always_comb begin
        enc_word = '0;
        legal    = 1'b1;
        if (in_opcode <= 4'd4)
            enc_word = {3'b000, in_rs2, in_rs1, in_rd, in_opcode};
        else if (in_opcode <= 4'd8)
            enc_word = {in_imm, in_rs1, in_rd, in_opcode};
        else if (in_opcode == 4'd9)
            enc_word = {4'b0000, in_jaddr, in_opcode};
        else
            legal = 1'b0;
    end

    assign addr_full = (state_q == HALT);
    assign in_ready  = !fifo_full && !addr_full && !start;
    assign accept    = in_valid && in_ready;
    // Illegal opcodes complete the handshake but never reach the FIFO.
    assign push      = accept && legal;

    enc_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (start),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt),
        .head_dat (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Enter WRITE on the accept edge so the word shows up one cycle later.
                    if (!fifo_empty || push) state_d = WRITE;
                end
                WRITE: begin
                    if (mem_ready) begin
                        pop = 1'b1;
                        if (!WRAP && (ptr_q == LAST_ADDR))
                            state_d = HALT;
                        else if ((fifo_cnt > CW'(1)) || push)
                            state_d = WRITE;
                        else
                            state_d = IDLE;
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        ptr_q <= '0;
        else if (start) ptr_q <= start_addr;
        else if (pop)   ptr_q <= ptr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    err_q <= 1'b0;
        else if (start)             err_q <= 1'b0;
        else if (accept && !legal)  err_q <= 1'b1;
    end

    assign err_illegal = err_q;
    assign mem_we      = (state_q == WRITE);
    assign mem_addr    = ptr_q;
    assign mem_wdata   = mem_we ? fifo_head : 16'h0000;
    assign busy        = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for packing plus sequences for backpressure, illegal, boundary and reset.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = 4'h0;
    logic [2:0]  in_rd = 3'h0;
    logic [2:0]  in_rs1 = 3'h0;
    logic [2:0]  in_rs2 = 3'h0;
    logic [5:0]  in_imm = 6'h00;
    logic [7:0]  in_jaddr = 8'h00;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        busy;
    logic        err_illegal;
    logic        addr_full;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [5:0]  imm;
        logic [7:0]  jaddr;
        logic [15:0] wdata;
        bit          legal;
    } vec_t;

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    vec_t vt[12];
    wr_t  wq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_jaddr    (in_jaddr),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .err_illegal (err_illegal),
        .addr_full   (addr_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after a rising edge, so a negedge sample is the handshake of the next edge.
    always @(negedge clk) begin
        if (mem_we && mem_ready) wq.push_back('{cyc, mem_addr, mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk_j(input logic [7:0] ja, input logic [15:0] wd);
        vec_t v;
        v = '{4'd9, 3'd0, 3'd0, 3'd0, 6'd0, ja, wd, 1'b1};
        return v;
    endfunction

    task automatic set_fields(input vec_t v);
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_jaddr  = v.jaddr;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        int n;
        set_fields(v);
        in_valid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 100) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_start(input logic [7:0] a);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_addr;
        bit         exp_err;
        bit         acc;
        vec_t       jv[5];
        int         base_c;

        vt[0]  = '{4'd2,  3'd3, 3'd5, 3'd6, 6'h00, 8'h00, 16'h1AB2, 1'b1};
        vt[1]  = '{4'd7,  3'd1, 3'd2, 3'd0, 6'h2A, 8'h00, 16'hA917, 1'b1};
        vt[2]  = '{4'd9,  3'd0, 3'd0, 3'd0, 6'h00, 8'hC3, 16'h0C39, 1'b1};
        vt[3]  = '{4'd0,  3'd7, 3'd7, 3'd7, 6'h00, 8'h00, 16'h1FF0, 1'b1};
        vt[4]  = '{4'd4,  3'd0, 3'd1, 3'd2, 6'h3F, 8'hFF, 16'h0884, 1'b1};
        vt[5]  = '{4'd5,  3'd6, 3'd4, 3'd0, 6'h3F, 8'h00, 16'hFE65, 1'b1};
        vt[6]  = '{4'd8,  3'd2, 3'd3, 3'd7, 6'h01, 8'h00, 16'h05A8, 1'b1};
        vt[7]  = '{4'd12, 3'd1, 3'd1, 3'd1, 6'h01, 8'h01, 16'h0000, 1'b0};
        vt[8]  = '{4'd9,  3'd7, 3'd7, 3'd0, 6'h00, 8'h00, 16'h0009, 1'b1};
        vt[9]  = '{4'd15, 3'd2, 3'd2, 3'd2, 6'h02, 8'h02, 16'h0000, 1'b0};
        vt[10] = '{4'd1,  3'd5, 3'd0, 3'd3, 6'h00, 8'h00, 16'h0C51, 1'b1};
        vt[11] = '{4'd6,  3'd4, 3'd1, 3'd0, 6'h15, 8'h00, 16'h54C6, 1'b1};
        jv[0] = mk_j(8'h11, 16'h0119);
        jv[1] = mk_j(8'h22, 16'h0229);
        jv[2] = mk_j(8'h33, 16'h0339);
        jv[3] = mk_j(8'h44, 16'h0449);
        jv[4] = mk_j(8'h55, 16'h0559);

        // Reset state
        #12;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_addr_full", addr_full, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Packing table, one request at a time, memory always ready
        mem_ready = 1'b1;
        do_start(8'h10);
        exp_addr = 8'h10;
        exp_err  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            send(vt[i]);
            @(negedge clk);
            if (vt[i].legal) begin
                chk($sformatf("vec%0d_we", i), mem_we, 1);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].wdata);
                chk($sformatf("vec%0d_addr", i), mem_addr, exp_addr);
                exp_addr = exp_addr + 8'd1;
            end else begin
                exp_err = 1'b1;
                chk($sformatf("vec%0d_no_we", i), mem_we, 0);
            end
            chk($sformatf("vec%0d_err", i), err_illegal, exp_err);
        end
        do_start(8'h00);
        @(negedge clk);
        chk("start_clears_err", err_illegal, 0);

        // Backpressure: memory stalled, FIFO fills after four accepts
        mem_ready = 1'b0;
        do_start(8'h20);
        for (int k = 0; k < 4; k++) send(jv[k]);
        @(negedge clk);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_we_held", mem_we, 1);
        chk("bp_addr_held", mem_addr, 8'h20);
        chk("bp_wdata_held", mem_wdata, 16'h0119);
        @(posedge clk);
        #1;
        wq.delete();
        set_fields(jv[4]);
        in_valid  = 1'b1;
        mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        chk("bp_5th_accepted", in_valid, 0);
        chk("bp_write_count", wq.size(), 5);
        base_c = (wq.size() > 0) ? wq[0].c : 0;
        for (int k = 0; k < 5; k++) begin
            if (k < wq.size()) begin
                chk($sformatf("bp%0d_addr", k), wq[k].a, 8'h20 + k[7:0]);
                chk($sformatf("bp%0d_data", k), wq[k].d, jv[k].wdata);
                chk($sformatf("bp%0d_cycle", k), wq[k].c - base_c, k);
            end
        end
        chk("bp_idle_busy", busy, 0);

        // Address-space boundary
        mem_ready = 1'b1;
        do_start(8'hFE);
        wq.delete();
        send(mk_j(8'h01, 16'h0019));
        send(mk_j(8'h02, 16'h0029));
        send(mk_j(8'h03, 16'h0039));
        repeat (6) @(posedge clk);
        @(negedge clk);
`ifdef ENC_ADDR_WRAP_EN
        chk("bnd_count", wq.size(), 3);
        chk("bnd_addr_full", addr_full, 0);
        chk("bnd_busy", busy, 0);
        if (wq.size() == 3) begin
            chk("bnd_w2_addr", wq[2].a, 8'h00);
            chk("bnd_w2_data", wq[2].d, 16'h0039);
        end
`else
        chk("bnd_count", wq.size(), 2);
        chk("bnd_addr_full", addr_full, 1);
        chk("bnd_in_ready", in_ready, 0);
        chk("bnd_we", mem_we, 0);
        chk("bnd_busy_held", busy, 1);
`endif
        if (wq.size() >= 2) begin
            chk("bnd_w0_addr", wq[0].a, 8'hFE);
            chk("bnd_w0_data", wq[0].d, 16'h0019);
            chk("bnd_w1_addr", wq[1].a, 8'hFF);
            chk("bnd_w1_data", wq[1].d, 16'h0029);
        end
        do_start(8'h00);
        @(negedge clk);
        chk("bnd_start_addr_full", addr_full, 0);
        chk("bnd_start_in_ready", in_ready, 1);
        chk("bnd_start_busy", busy, 0);

        // Asynchronous reset in the middle of a pending write
        mem_ready = 1'b0;
        do_start(8'h30);
        send(mk_j(8'h0A, 16'h00A9));
        send(mk_j(8'h0B, 16'h00B9));
        #2;
        chk("ar_we_before", mem_we, 1);
        chk("ar_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("ar_we_async", mem_we, 0);
        chk("ar_busy_async", busy, 0);
        chk("ar_addr_async", mem_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("ar_no_stale", wq.size(), 0);
        chk("ar_addr_after", mem_addr, 0);
        chk("ar_busy_after", busy, 0);
        chk("ar_we_after", mem_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
